qspi_flash_responder: RTL and testbench
=======================================

Name: qspi_flash_responder

Overview:
- Synthesizable QSPI flash target model. It is the responder end of the link that qspi_flashmem drives.
- Sits in simulation benches and loopback builds in place of the real flash, answering qspi_flashmem's reads from a byte-wide memory port (ROM/BRAM image).
- Supports single-line Read (0x03) and Quad I/O Fast Read (0xEB), including continuous-read (command-skip) mode.
- All SPI pins are oversampled in the clk domain; there is no SPI-clocked logic.

Parameters:
- ADDR_W, 24, byte address width presented on mem_addr (low ADDR_W bits of the 24-bit SPI address).
- DUMMY_CYC, 4, dummy SCLK cycles after the mode byte for 0xEB.

Ports:
- clk  in  1  system clock; spi_sclk period must be >= 8 clk periods.
- reset  in  1  synchronous, active-low reset.
- spi_sclk  in  1  SPI clock from initiator (mode 0: idle low).
- spi_cs_n  in  1  chip select, active low.
- io_in  in  4  {hold_n, wp_n, miso, mosi} pad inputs; io_in[0]=mosi.
- io_out  out  4  pad output values.
- io_oe  out  4  per-pad output enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_rd.
- busy  out  1  high while a transaction is in progress.
- cmd_err  out  1  one-clk pulse on an unsupported command byte.

Behaviour:
- Reset (reset==0 at posedge clk): every output is 0, io_oe=0000, state IDLE, continuous mode cleared, synchronizers loaded with sclk=0, cs_n=1.
- Synchronization: spi_sclk, spi_cs_n and io_in each pass through 2-flop synchronizers.
  - rise/fall are detected from the 2nd and 3rd flop.
  - io is sampled from the same delay stage as sclk, so data and clock stay aligned.
- cs_n rising (deasserted) in any state: next state IDLE, io_oe=0000 next cycle, busy=0. The continuous flag is kept.
- cs_n falling:
  - If the continuous flag is set, go to ADDR in quad mode.
  - Otherwise go to CMD.
  - busy=1.
- States and transitions:
  - CMD: shift io_in[0] MSB-first on 8 rises.
    - 0x03 -> ADDR (single line).
    - 0xEB -> ADDR (quad).
    - Any other value -> IGNORE and pulse cmd_err.
  - ADDR: single mode takes 24 rises of io_in[0]; quad mode takes 6 rises of io_in[3:0], high nibble first.
    - At the last rise, set mem_addr to the address and pulse mem_rd.
    - Single -> DATA. Quad -> MODE.
  - MODE: 2 rises, nibbles. When complete, continuous flag <= (mode[5:4]==2'b10). -> DUMMY.
  - DUMMY: count DUMMY_CYC rises, then -> DATA.
  - DATA: drive on each fall.
    - Single: io_oe=0010, io_out[1]=byte bit MSB-first.
    - Quad: io_oe=1111, io_out=nibble, high first.
    - Outputs update 1 clk after the detected fall and hold until the next fall.
    - On the fall that drives the first bit/nibble of a byte, increment the address (wrap at 2^ADDR_W - 1 -> 0) and pulse mem_rd, prefetching the next byte into a holding register.
    - The data stream is unbounded until cs_n rises.
  - IGNORE: io_oe=0000 until cs_n rises.
- Byte latch: mem_rdata is captured 1 clk after each mem_rd. The current shift byte loads from the latch at each byte boundary.
- First data edge: the initiator's first data-phase fall follows the last address/dummy rise. The fetched byte is loaded before that fall is serviced.
- Simultaneous cs_n rise and sclk edge: cs_n wins; the edge is ignored.
- sclk edges while cs_n is high are ignored.
- reset mid-transaction: immediate return to the reset state, including the continuous flag.

Test Plan:
- Quad read, memory[i]=i[7:0]: cmd 0xEB, addr 0x000010, mode 0x00, 4 dummy, 8 data clocks -> io nibbles 1,0,1,1,1,2,1,3; mem_rd pulses at addr 0x10..0x14; io_oe=1111 only in DATA.
- Single read 0x03, addr 0x55AACC, 16 data clocks -> miso bits give bytes 0xCC then 0xCD (memory[i]=i[7:0]); io_oe=0010.
- Continuous mode: 0xEB with mode 0xA0; next cs cycle sends addr 0x000020 with no cmd -> data 0x20; a later mode 0xFF clears the flag, so the following cycle expects a cmd.
- Unsupported cmd 0x9F -> one-clk cmd_err pulse, io_oe stays 0000, no mem_rd; next cs cycle with 0xEB works.
- Wrap: ADDR_W=24, quad read at 0xFFFFFF for 2 bytes -> second mem_addr = 0x000000.
- Abort/reset: cs_n raised after 3 address nibbles -> IDLE, busy=0, io_oe=0000 within 3 clk. reset low during DATA -> all outputs 0 next clk, continuous flag cleared.

Source files
------------

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
//   Synthesizable QSPI flash target. It answers Read (0x03) and Quad I/O Fast
//   Read (0xEB), including continuous-read (command-skip) mode, from a
//   byte-wide memory port. Every SPI pin is oversampled in the clk domain.
//
// Ports
//   clk        system clock (spi_sclk period >= 8 clk)
//   reset      synchronous, active-low reset
//   spi_sclk   SPI clock, mode 0
//   spi_cs_n   chip select, active low
//   io_in      {hold_n, wp_n, miso, mosi} pad inputs
//   io_out     pad output values
//   io_oe      per-pad output enable
//   mem_addr   memory byte address
//   mem_rd     one-cycle read strobe
//   mem_rdata  read data, valid 1 clk after mem_rd
//   busy       transaction in progress
//   cmd_err    one-clk pulse on an unsupported command byte
module qspi_flash_responder #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DUMMY_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_MODE,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_e;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

  // Synchronizers: [0] first flop, [1] second, [2] edge-detect history.
  logic [2:0]        sclk_q;
  logic [2:0]        cs_q;
  logic [3:0]        io_s1_q, io_s2_q;

  state_e            state_q, state_d;
  logic              quad_q, quad_d;
  logic              cont_q, cont_d;
  logic [22:0]       sh_q, sh_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        dbit_q, dbit_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        latch_q, latch_d;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              cmd_err_q, cmd_err_d;
  logic [3:0]        io_out_q, io_out_d;
  logic [3:0]        io_oe_q, io_oe_d;

  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [23:0]       sh_bit, sh_nib, sh_new;
  logic [7:0]        cur;

  // io_s2_q is the same delay stage as sclk_q[1], so data sampled on a
  // detected rise is the value present at that SPI edge.
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];

  assign sh_bit = {sh_q[22:0], io_s2_q[0]};
  assign sh_nib = {sh_q[19:0], io_s2_q};
  assign sh_new = quad_q ? sh_nib : sh_bit;

  always_comb begin
    state_d    = state_q;
    quad_d     = quad_q;
    cont_d     = cont_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    dbit_d     = dbit_q;
    byte_d     = byte_q;
    latch_d    = rd_pend_q ? mem_rdata : latch_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    cmd_err_d  = 1'b0;
    io_out_d   = io_out_q;
    io_oe_d    = 4'b0000;
    cur        = byte_q;

    // cs_n deassertion wins over any simultaneous sclk edge.
    if (cs_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            cnt_d = '0;
            if (cont_q) begin
              state_d = S_ADDR;
              quad_d  = 1'b1;
            end else begin
              state_d = S_CMD;
              quad_d  = 1'b0;
            end
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            sh_d  = sh_bit[22:0];
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_d = '0;
              case (sh_bit[7:0])
                8'h03: begin
                  state_d = S_ADDR;
                  quad_d  = 1'b0;
                end
                8'hEB: begin
                  state_d = S_ADDR;
                  quad_d  = 1'b1;
                end
                default: begin
                  state_d   = S_IGNORE;
                  cmd_err_d = 1'b1;
                end
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            sh_d  = sh_new[22:0];
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == (quad_q ? 8'd5 : 8'd23)) begin
              cnt_d      = '0;
              dbit_d     = '0;
              mem_addr_d = sh_new[ADDR_W-1:0];
              mem_rd_d   = 1'b1;
              state_d    = quad_q ? S_MODE : S_DATA;
            end
          end
        end
        S_MODE: begin
          if (sclk_rise) begin
            sh_d  = sh_nib[22:0];
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd1) begin
              cnt_d   = '0;
              cont_d  = (sh_nib[5:4] == 2'b10);
              state_d = (DUMMY_CYC == 0) ? S_DATA : S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = '0;
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (sclk_fall) begin
            // First bit/nibble of a byte comes from the prefetch latch, and
            // that same fall launches the fetch of the following byte.
            if (dbit_q == 3'd0) begin
              cur        = latch_q;
              mem_addr_d = mem_addr_q + ADDR_W'(1);
              mem_rd_d   = 1'b1;
            end
            if (quad_q) begin
              io_out_d = cur[7:4];
              byte_d   = {cur[3:0], 4'b0000};
              dbit_d   = {2'b00, ~dbit_q[0]};
            end else begin
              io_out_d = {2'b00, cur[7], 1'b0};
              byte_d   = {cur[6:0], 1'b0};
              dbit_d   = dbit_q + 3'd1;
            end
          end
        end
        S_IGNORE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_DATA) begin
      io_oe_d = quad_d ? 4'b1111 : 4'b0010;
    end else begin
      io_out_d = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_q     <= '0;
      cs_q       <= '1;
      io_s1_q    <= '0;
      io_s2_q    <= '0;
      state_q    <= S_IDLE;
      quad_q     <= 1'b0;
      cont_q     <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      dbit_q     <= '0;
      byte_q     <= '0;
      latch_q    <= '0;
      rd_pend_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      io_out_q   <= '0;
      io_oe_q    <= '0;
    end else begin
      sclk_q     <= {sclk_q[1:0], spi_sclk};
      cs_q       <= {cs_q[1:0], spi_cs_n};
      io_s1_q    <= io_in;
      io_s2_q    <= io_s1_q;
      state_q    <= state_d;
      quad_q     <= quad_d;
      cont_q     <= cont_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      dbit_q     <= dbit_d;
      byte_q     <= byte_d;
      latch_q    <= latch_d;
      rd_pend_q  <= mem_rd_q;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      cmd_err_q  <= cmd_err_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
    end
  end

  assign io_out   = io_out_q;
  assign io_oe    = io_oe_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder
//   Directed bench for qspi_flash_responder: acts as the QSPI initiator and
//   as a byte memory holding memory[i] = i[7:0].
`timescale 1ns/1ps
module tb_qspi_flash_responder;

  localparam int HALF  = 5;   // clk periods per sclk half period
  localparam int DUMMY = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic [3:0]  io_in = 4'b1100;
  logic [3:0]  io_out;
  logic [3:0]  io_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        cmd_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;
  logic [23:0] rd_q[$];

  qspi_flash_responder #(
    .ADDR_W   (24),
    .DUMMY_CYC(DUMMY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  // Memory image: data = low byte of the address, valid 1 clk after mem_rd.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

  always @(negedge clk) begin
    if (mem_rd) rd_q.push_back(mem_addr);
    if (cmd_err) err_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_cycle(input logic [3:0] v);
    io_in = v;
    wait_clk(HALF);
    spi_sclk = 1'b1;
    wait_clk(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sclk_cycle({3'b110, b[i]});
  endtask

  task automatic send_addr_quad(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) sclk_cycle(a[i*4 +: 4]);
  endtask

  // Last clock: sclk falls together with cs_n rising, so that fall is ignored.
  task automatic read_clock(input bit last, output logic [3:0] v, output logic [3:0] oe);
    wait_clk(HALF);
    spi_sclk = 1'b1;
    v  = io_out;
    oe = io_oe;
    wait_clk(HALF);
    spi_sclk = 1'b0;
    if (last) spi_cs_n = 1'b1;
  endtask

  task automatic quad_txn(input bit with_cmd, input logic [23:0] addr, input logic [7:0] mode,
                          input int nbytes, output logic [31:0] data,
                          output logic [3:0] oe_addr, output logic oe_ok);
    logic [3:0] v, oe;
    data  = '0;
    oe_ok = 1'b1;
    cs_low();
    if (with_cmd) send_cmd(8'hEB);
    send_addr_quad(addr);
    oe_addr = io_oe;
    sclk_cycle(mode[7:4]);
    sclk_cycle(mode[3:0]);
    repeat (DUMMY) sclk_cycle(4'h0);
    for (int i = 0; i < 2 * nbytes; i++) begin
      read_clock(i == 2 * nbytes - 1, v, oe);
      data = {data[27:0], v};
      if (oe !== 4'hF) oe_ok = 1'b0;
    end
    wait_clk(8);
  endtask

  function automatic logic [31:0] rd_at(input int i);
    return (rd_q.size() > i) ? {8'h00, rd_q[i]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [31:0] d;
    logic [3:0]  oe_a, v, oe;
    logic        ok;
    logic [23:0] sa;
    int          e0;

    // Reset state
    wait_clk(4);
    check("rst_io_out", {28'h0, io_out}, 32'h0);
    check("rst_io_oe", {28'h0, io_oe}, 32'h0);
    check("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
    check("rst_strobes", {29'h0, mem_rd, busy, cmd_err}, 32'h0);
    reset = 1'b1;
    wait_clk(4);

    // Quad read at 0x10, mode 0x00, 4 bytes
    rd_q.delete();
    quad_txn(1'b1, 24'h000010, 8'h00, 4, d, oe_a, ok);
    check("quad_data", d, 32'h1011_1213);
    check("quad_oe_addr", {28'h0, oe_a}, 32'h0);
    check("quad_oe_data", {31'h0, ok}, 32'h1);
    check("quad_rd_count", rd_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) check("quad_rd_addr", rd_at(i), 32'h10 + i);
    check("quad_idle_busy", {31'h0, busy}, 32'h0);
    check("quad_idle_oe", {28'h0, io_oe}, 32'h0);

    // Single read 0x03 at 0x55AACC, 2 bytes
    rd_q.delete();
    sa = 24'h55AACC;
    cs_low();
    check("single_busy", {31'h0, busy}, 32'h1);
    send_cmd(8'h03);
    check("single_oe_addr", {28'h0, io_oe}, 32'h0);
    for (int i = 23; i >= 0; i--) sclk_cycle({3'b110, sa[i]});
    d  = '0;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_clock(i == 15, v, oe);
      d = {d[30:0], v[1]};
      if (oe !== 4'b0010) ok = 1'b0;
    end
    wait_clk(8);
    check("single_data", d, 32'h0000_CCCD);
    check("single_oe", {31'h0, ok}, 32'h1);
    check("single_rd_count", rd_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) check("single_rd_addr", rd_at(i), 32'h55AACC + i);

    // Continuous mode: enter with 0xA0, skip cmd, leave with 0xFF
    quad_txn(1'b1, 24'h000030, 8'hA0, 1, d, oe_a, ok);
    check("cont_enter", d, 32'h30);
    quad_txn(1'b0, 24'h000020, 8'hA0, 1, d, oe_a, ok);
    check("cont_skip1", d, 32'h20);
    quad_txn(1'b0, 24'h000040, 8'hFF, 1, d, oe_a, ok);
    check("cont_skip2", d, 32'h40);
    quad_txn(1'b1, 24'h000048, 8'h00, 1, d, oe_a, ok);
    check("cont_cleared", d, 32'h48);
    check("cont_no_err", err_cnt, 32'd0);

    // Unsupported command 0x9F
    rd_q.delete();
    e0 = err_cnt;
    cs_low();
    send_cmd(8'h9F);
    repeat (4) sclk_cycle(4'h0);
    check("bad_oe", {28'h0, io_oe}, 32'h0);
    check("bad_busy", {31'h0, busy}, 32'h1);
    spi_cs_n = 1'b1;
    wait_clk(8);
    check("bad_err_pulse", err_cnt - e0, 32'd1);
    check("bad_no_rd", rd_q.size(), 32'd0);
    quad_txn(1'b1, 24'h000050, 8'h00, 1, d, oe_a, ok);
    check("bad_recover", d, 32'h50);

    // Address wrap
    rd_q.delete();
    quad_txn(1'b1, 24'hFFFFFF, 8'h00, 2, d, oe_a, ok);
    check("wrap_data", d, 32'hFF00);
    check("wrap_rd_count", rd_q.size(), 32'd3);
    check("wrap_rd_first", rd_at(0), 32'hFFFFFF);
    check("wrap_rd_second", rd_at(1), 32'h000000);

    // Abort after 3 address nibbles
    cs_low();
    send_cmd(8'hEB);
    repeat (3) sclk_cycle(4'h7);
    check("abort_busy_pre", {31'h0, busy}, 32'h1);
    spi_cs_n = 1'b1;
    wait_clk(3);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_oe", {28'h0, io_oe}, 32'h0);
    wait_clk(5);

    // Reset during DATA with continuous flag set
    cs_low();
    send_cmd(8'hEB);
    send_addr_quad(24'h000070);
    sclk_cycle(4'hA);
    sclk_cycle(4'h0);
    repeat (DUMMY) sclk_cycle(4'h0);
    read_clock(1'b0, v, oe);
    check("rstd_pre_oe", {28'h0, io_oe}, 32'hF);
    check("rstd_pre_nib", {28'h0, v}, 32'h7);
    reset = 1'b0;
    wait_clk(1);
    check("rstd_outs", {25'h0, io_out, mem_rd, busy, cmd_err}, 32'h0);
    check("rstd_oe", {28'h0, io_oe}, 32'h0);
    check("rstd_addr", {8'h0, mem_addr}, 32'h0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(4);
    quad_txn(1'b1, 24'h000060, 8'h00, 1, d, oe_a, ok);
    check("rstd_cont_cleared", d, 32'h60);
    check("total_cmd_err", err_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
